// File: rtl/pwm_timer_ctrl.sv
// Control stage for a free-running up-counter: prescaler, period wrap and PWM duty compare,
// with a one-deep shadow configuration slot applied only at period boundaries.
module pwm_timer_ctrl #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [WIDTH-1:0]       cfg_period_i,
  input  logic [WIDTH-1:0]       cfg_duty_i,
  input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
  input  logic [WIDTH-1:0]       count_i,
  output logic                   clear_o,
  output logic                   enable_o,
  output logic                   pwm_o,
  output logic                   period_o,
  output logic                   busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [WIDTH-1:0]       act_period_q;
  logic [WIDTH-1:0]       act_duty_q;
  logic [PRESC_WIDTH-1:0] act_presc_q;
  logic [WIDTH-1:0]       pend_period_q;
  logic [WIDTH-1:0]       pend_duty_q;
  logic [PRESC_WIDTH-1:0] pend_presc_q;
  logic                   pend_valid_q;
  logic [PRESC_WIDTH-1:0] presc_cnt_q;
  logic [PRESC_WIDTH-1:0] presc_cnt_d;
  logic                   pwm_q;

  logic run;
  logic tick;
  logic wrap;
  logic start_go;
  logic stop_go;
  logic load;
  logic accept;

  assign run      = (state_q == RUN);
  assign tick     = run && (presc_cnt_q == act_presc_q);
  assign wrap     = tick && (count_i == act_period_q);
  assign start_go = !run && start_i && !stop_i;
  assign stop_go  = run && stop_i;
  // A stop overrides a coincident wrap, so the shadow slot is then kept for the next start.
  assign load     = pend_valid_q && (start_go || (wrap && !stop_go));
  assign accept   = cfg_valid_i && !pend_valid_q;

  assign clear_o     = start_go || stop_go || wrap;
  assign enable_o    = tick && !wrap && !stop_go;
  assign period_o    = wrap && !stop_go;
  assign busy_o      = run;
  assign cfg_ready_o = !pend_valid_q;
  assign pwm_o       = pwm_q;

  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
    if (!run || stop_go || tick) begin
      presc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      act_presc_q   <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_presc_q  <= '0;
      pend_valid_q  <= 1'b0;
      presc_cnt_q   <= '0;
      pwm_q         <= 1'b0;
    end else begin
      if (start_go) begin
        state_q <= RUN;
      end else if (stop_go) begin
        state_q <= IDLE;
      end
      presc_cnt_q <= presc_cnt_d;

      // accept and load are mutually exclusive: one needs the slot empty, the other full.
      if (accept) begin
        pend_period_q <= cfg_period_i;
        pend_duty_q   <= cfg_duty_i;
        pend_presc_q  <= cfg_presc_i;
        pend_valid_q  <= 1'b1;
      end else if (load) begin
        pend_valid_q  <= 1'b0;
      end

      if (load) begin
        act_period_q <= pend_period_q;
        act_duty_q   <= pend_duty_q;
        act_presc_q  <= pend_presc_q;
      end

      pwm_q <= run && (count_i < act_duty_q);
    end
  end

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Bench for pwm_timer_ctrl: attached counter, elapsed-time reference model, a vector table,
// directed corner-case sequences and a randomized run.
module tb_pwm_timer_ctrl;
  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, stop, cfg_valid, cfg_ready;
  logic [W-1:0]  cfg_period, cfg_duty;
  logic [PW-1:0] cfg_presc;
  logic [W-1:0]  count;
  logic          clear, enable, pwm, period, busy;

  always #5 clk = ~clk;

  pwm_timer_ctrl #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_period_i(cfg_period), .cfg_duty_i(cfg_duty), .cfg_presc_i(cfg_presc),
    .count_i(count), .clear_o(clear), .enable_o(enable), .pwm_o(pwm),
    .period_o(period), .busy_o(busy)
  );

  // The free-running up-counter the block controls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 16'd1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles in the current period, active config, one pending slot.
  bit m_run, m_pv, m_pwm;
  int m_e, m_per, m_duty, m_presc;
  int p_per, p_duty, p_presc;
  bit o_clr, o_en, o_per, o_pwm, o_rdy, o_busy;

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_pwm = 0; m_e = 0;
    m_per = 0; m_duty = 0; m_presc = 0;
    p_per = 0; p_duty = 0; p_presc = 0;
  endtask

  task automatic apply_pending();
    m_per = p_per; m_duty = p_duty; m_presc = p_presc; m_pv = 0;
  endtask

  task automatic cyc(input bit st, input bit sp, input bit cv);
    bit e_clr, e_en, e_per, tk, wr, acc, nxt_pwm;
    int cnt;
    start = st; stop = sp; cfg_valid = cv;
    @(negedge clk);
    cnt = 0; tk = 0; wr = 0;
    if (m_run) begin
      cnt = m_e / (m_presc + 1);
      tk  = (m_e % (m_presc + 1)) == m_presc;
      wr  = tk && (cnt == m_per);
    end
    if (!m_run) begin
      e_clr = st && !sp; e_en = 0; e_per = 0;
    end else if (sp) begin
      e_clr = 1; e_en = 0; e_per = 0;
    end else begin
      e_clr = wr; e_en = tk && !wr; e_per = wr;
    end
    chk1("clear_o", clear, e_clr);
    chk1("enable_o", enable, e_en);
    chk1("period_o", period, e_per);
    chk1("busy_o", busy, m_run);
    chk1("cfg_ready_o", cfg_ready, !m_pv);
    chk1("pwm_o", pwm, m_pwm);
    if (m_run) chkn("count_i", int'(count), cnt);
    o_clr = clear; o_en = enable; o_per = period; o_pwm = pwm; o_rdy = cfg_ready; o_busy = busy;

    nxt_pwm = m_run && (cnt < m_duty);
    acc = cv && !m_pv;
    if (!m_run) begin
      if (st && !sp) begin
        if (m_pv) apply_pending();
        m_run = 1; m_e = 0;
      end
    end else if (sp) begin
      m_run = 0;
    end else if (wr) begin
      m_e = 0;
      if (m_pv) apply_pending();
    end else begin
      m_e++;
    end
    if (acc) begin
      p_per = int'(cfg_period); p_duty = int'(cfg_duty); p_presc = int'(cfg_presc); m_pv = 1;
    end
    m_pwm = nxt_pwm;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int per, input int duty, input int pr);
    cfg_period = W'(per); cfg_duty = W'(duty); cfg_presc = PW'(pr);
  endtask

  // Stop, offer a config in IDLE, then start with it.
  task automatic reconf(input int per, input int duty, input int pr);
    cyc(0, 1, 0);
    set_cfg(per, duty, pr);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
  endtask

  task automatic window(input int n, output int c_per, output int c_en,
                        output int c_pwm, output int c_clr);
    c_per = 0; c_en = 0; c_pwm = 0; c_clr = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0);
      c_per += int'(o_per); c_en += int'(o_en); c_pwm += int'(o_pwm); c_clr += int'(o_clr);
    end
  endtask

  typedef struct packed {
    logic st, sp, cv;
    logic clr, en, prd, bsy, rdy, pw;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int np, ne, nw, nc, gap;
    bit seen;

    // Basic run from reset: period 9, duty 3, presc 0 (cfg held constant across the table).
    //            st sp cv  clr en prd bsy rdy pwm
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rstn = 1'b0; start = 0; stop = 0; cfg_valid = 0;
    set_cfg(0, 0, 0);
    model_reset();
    #2;
    chk1("reset clear_o", clear, 1'b0);
    chk1("reset enable_o", enable, 1'b0);
    chk1("reset period_o", period, 1'b0);
    chk1("reset pwm_o", pwm, 1'b0);
    chk1("reset busy_o", busy, 1'b0);
    chk1("reset cfg_ready_o", cfg_ready, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;

    set_cfg(9, 3, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].cv);
      chkn($sformatf("vector %0d", i),
           int'({o_clr, o_en, o_per, o_busy, o_rdy, o_pwm}),
           int'({tbl[i].clr, tbl[i].en, tbl[i].prd, tbl[i].bsy, tbl[i].rdy, tbl[i].pw}));
    end
    window(5, np, ne, nw, nc);
    window(20, np, ne, nw, nc);
    chkn("basic period_o per 20", np, 2);
    chkn("basic pwm high per 20", nw, 6);
    chkn("basic clear_o per 20", nc, 2);

    // Prescaler: 15-cycle period, 4 enables, pwm high for counts 0..1 (6 cycles).
    reconf(4, 2, 2);
    window(15, np, ne, nw, nc);
    window(30, np, ne, nw, nc);
    chkn("presc enable_o per 30", ne, 8);
    chkn("presc period_o per 30", np, 2);
    chkn("presc pwm high per 30", nw, 12);

    // Shadow update mid-period: old 10-cycle period completes first.
    reconf(9, 3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    set_cfg(4, 5, 0);
    cyc(0, 0, 1);
    chk1("shadow ready before accept", o_rdy, 1'b1);
    seen = 0; gap = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 0, 0);
      gap++;
      if (o_per) seen = 1;
      else chk1("shadow ready while pending", o_rdy, 1'b0);
    end
    chk1("shadow old wrap seen", seen, 1'b1);
    chkn("shadow cycles to old wrap", gap, 5);
    chk1("shadow ready in wrap cycle", o_rdy, 1'b0);
    cyc(0, 0, 0);
    chk1("shadow ready after wrap", o_rdy, 1'b1);
    gap = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 0, 0);
      gap++;
      if (o_per) seen = 1;
    end
    chk1("shadow new wrap seen", seen, 1'b1);
    chkn("shadow new period length", gap, 5);
    window(10, np, ne, nw, nc);
    chkn("shadow pwm high per 10", nw, 10);
    chkn("shadow period_o per 10", np, 2);

    // Edge duties and the zero period.
    reconf(9, 0, 0);
    window(12, np, ne, nw, nc);
    window(20, np, ne, nw, nc);
    chkn("duty0 pwm high", nw, 0);
    reconf(9, 16'hFFFF, 0);
    window(12, np, ne, nw, nc);
    window(20, np, ne, nw, nc);
    chkn("dutymax pwm high", nw, 20);
    reconf(0, 1, 0);
    window(10, np, ne, nw, nc);
    chkn("period0 period_o", np, 10);
    chkn("period0 enable_o", ne, 0);

    // Collisions.
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk1("idle start+stop clear_o", o_clr, 1'b0);
    cyc(0, 0, 0);
    chk1("idle start+stop stays idle", o_busy, 1'b0);
    set_cfg(9, 3, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk1("run start+stop clear_o", o_clr, 1'b1);
    cyc(0, 0, 0);
    chk1("run start+stop to idle", o_busy, 1'b0);
    cyc(1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk1("stop on wrap period_o", o_per, 1'b0);
    chk1("stop on wrap clear_o", o_clr, 1'b1);

    // Asynchronous reset mid-RUN with a pending config.
    reconf(9, 3, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    set_cfg(5, 2, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk1("async reset clear_o", clear, 1'b0);
    chk1("async reset enable_o", enable, 1'b0);
    chk1("async reset period_o", period, 1'b0);
    chk1("async reset pwm_o", pwm, 1'b0);
    chk1("async reset busy_o", busy, 1'b0);
    chk1("async reset cfg_ready_o", cfg_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    window(10, np, ne, nw, nc);
    chkn("post reset clear_o", nc, 0);
    chkn("post reset enable_o", ne, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      set_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
              int'($urandom_range(0, 3)));
      cyc($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
